// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared types, constants and sample encoding for the ADC capture uploader.
//   state_t          : uploader FSM states
//   CMD_CAPTURE      : command type that starts a capture
//   HDR_BYTES        : bytes of command header that are decoded
//   UPLOAD_HDR_BYTES : bytes of upload packet header
//   OFFSET           : offset-binary bias for 14-bit samples
//   encode_sample    : signed 14-bit sample -> {byte B, byte A}
package adc_capture_pkg;

    localparam logic [7:0]  CMD_CAPTURE      = 8'hFD;
    localparam int          HDR_BYTES        = 7;
    localparam int          UPLOAD_HDR_BYTES = 3;
    localparam logic [13:0] OFFSET           = 14'd8192;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECEIVING,
        S_PARSE,
        S_ARM,
        S_CAPTURE,
        S_SEND_HDR,
        S_SEND_DATA
    } state_t;

    // Inverse of the playback decode: offset-binary, low byte first on the wire.
    function automatic logic [15:0] encode_sample(input logic signed [13:0] s);
        logic [13:0] raw;
        raw = s + OFFSET;
        return {2'b00, raw[13:8], raw[7:0]};
    endfunction

endpackage

// File: rtl/adc_capture_ram.sv
// capture_ram: simple dual-port sample RAM, one write port and one registered read port.
//   clk     : clock
//   i_we    : write enable
//   i_waddr : write address
//   i_wdata : write data
//   i_raddr : read address
//   o_rdata : read data, one cycle after i_raddr
module capture_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 14
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        o_rdata <= r_mem[i_raddr];
    end

endmodule

// File: rtl/adc_capture_uploader.sv
// adc_capture_uploader: receives a 0xFD capture command, captures (optionally triggered,
// decimated) ADC samples into RAM, then uploads them as a byte packet.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   cmd_type/length/data/index    : shared command bus fields
//   cmd_start/data_valid/done     : command bus strobes
//   cmd_ready                     : high while able to take a command (IDLE/RECEIVING)
//   abort                         : level, returns to IDLE and drops any packet in flight
//   adc_data, adc_valid           : signed 14-bit sample stream
//   upload_data/valid/ready       : byte upload port (valid/ready)
//   busy                          : high in any state but IDLE
//   capture_done                  : one-cycle pulse after the last sample is written
module adc_capture_uploader
    import adc_capture_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [7:0]         cmd_type,
    input  logic [15:0]        cmd_length,
    input  logic [7:0]         cmd_data,
    input  logic [15:0]        cmd_data_index,
    input  logic               cmd_start,
    input  logic               cmd_data_valid,
    input  logic               cmd_done,
    output logic               cmd_ready,
    input  logic               abort,
    input  logic signed [13:0] adc_data,
    input  logic               adc_valid,
    output logic [7:0]         upload_data,
    output logic               upload_valid,
    input  logic               upload_ready,
    output logic               busy,
    output logic               capture_done
);

    localparam logic [15:0] DEPTH_L = 16'(DEPTH);

    state_t            r_state;
    logic [7:0]        r_hdr [HDR_BYTES];
    logic [15:0]       r_len;
    logic [31:0]       r_rate;
    logic [31:0]       r_phase;
    logic [13:0]       r_prev;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [15:0]       r_loaded;
    logic [7:0]        r_byte_b;
    logic [7:0]        r_up_data;
    logic              r_up_valid;
    logic              r_done;

    logic [15:0] w_len_raw;
    logic [15:0] w_len_clamp;
    logic [15:0] w_total;
    logic [32:0] w_phase_next;
    logic        w_cross;
    logic        w_cand;
    logic        w_take;
    logic        w_we;
    logic        w_last;
    logic        w_load;
    logic [13:0] w_ram_q;
    logic [15:0] w_enc;
    logic        w_unused;

    assign w_len_raw    = {r_hdr[1], r_hdr[2]};
    assign w_len_clamp  = (w_len_raw > DEPTH_L) ? DEPTH_L : w_len_raw;
    assign w_total      = 16'(UPLOAD_HDR_BYTES) + {r_len[14:0], 1'b0};
    assign w_phase_next = {1'b0, r_phase} + {1'b0, r_rate};
    // Rising zero crossing: previous sample negative, current one non-negative.
    assign w_cross      = r_prev[13] && !adc_data[13];
    // The triggering sample already goes through decimation like any capture sample.
    assign w_cand       = adc_valid && ((r_state == S_CAPTURE) || (r_state == S_ARM && w_cross));
    assign w_take       = (r_rate == 32'd0) || w_phase_next[32];
    assign w_we         = w_cand && w_take;
    assign w_last       = (16'(r_wr_ptr) == r_len - 16'd1);
    // Output register is free when empty or being consumed this cycle.
    assign w_load       = !r_up_valid || upload_ready;
    assign w_enc        = encode_sample(w_ram_q);
    assign w_unused     = ^{cmd_length, r_hdr[0][7:1], r_len[15]};

    assign cmd_ready    = (r_state == S_IDLE) || (r_state == S_RECEIVING);
    assign busy         = (r_state != S_IDLE);
    assign upload_data  = r_up_data;
    assign upload_valid = r_up_valid;
    assign capture_done = r_done;

    capture_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (14)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (adc_data),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_ram_q)
    );

    // r_rd_ptr always points at the next sample to send, so the registered RAM output
    // already holds it when its low byte is loaded; the high byte is kept in r_byte_b.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            for (int i = 0; i < HDR_BYTES; i++) r_hdr[i] <= '0;
            r_len      <= '0;
            r_rate     <= '0;
            r_phase    <= '0;
            r_prev     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_loaded   <= '0;
            r_byte_b   <= '0;
            r_up_data  <= '0;
            r_up_valid <= 1'b0;
            r_done     <= 1'b0;
        end else if (abort) begin
            r_state    <= S_IDLE;
            r_phase    <= '0;
            r_prev     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_loaded   <= '0;
            r_up_valid <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_cand) r_phase <= w_phase_next[31:0];
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_last) begin
                    r_done  <= 1'b1;
                    r_state <= S_SEND_HDR;
                end
            end
            case (r_state)
                S_IDLE: if (cmd_start && cmd_type == CMD_CAPTURE) r_state <= S_RECEIVING;
                S_RECEIVING: begin
                    if (cmd_data_valid && cmd_data_index < 16'(HDR_BYTES))
                        r_hdr[cmd_data_index[2:0]] <= cmd_data;
                    if (cmd_done) r_state <= S_PARSE;
                end
                S_PARSE: begin
                    r_len    <= w_len_clamp;
                    r_rate   <= {r_hdr[3], r_hdr[4], r_hdr[5], r_hdr[6]};
                    r_phase  <= '0;
                    r_prev   <= '0;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                    r_loaded <= '0;
                    r_state  <= (w_len_clamp == 16'd0) ? S_SEND_HDR :
                                r_hdr[0][0]             ? S_ARM      : S_CAPTURE;
                end
                S_ARM: if (adc_valid) begin
                    r_prev <= adc_data;
                    if (w_cross && !(w_we && w_last)) r_state <= S_CAPTURE;
                end
                S_SEND_HDR: if (w_load) begin
                    r_up_valid <= 1'b1;
                    r_up_data  <= (r_loaded == 16'd0) ? CMD_CAPTURE :
                                  (r_loaded == 16'd1) ? r_len[15:8] : r_len[7:0];
                    r_loaded   <= r_loaded + 16'd1;
                    if (r_loaded == 16'(UPLOAD_HDR_BYTES - 1)) r_state <= S_SEND_DATA;
                end
                S_SEND_DATA: if (w_load) begin
                    if (r_loaded == w_total) begin
                        r_up_valid <= 1'b0;
                        r_state    <= S_IDLE;
                    end else begin
                        // Odd byte count means the header (3 bytes) plus whole samples: low byte next.
                        r_loaded  <= r_loaded + 16'd1;
                        r_up_data <= r_loaded[0] ? w_enc[7:0] : r_byte_b;
                        if (r_loaded[0]) begin
                            r_byte_b <= w_enc[15:8];
                            r_rd_ptr <= r_rd_ptr + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture_uploader.sv
// tb_adc_capture_uploader: directed self-checking bench for adc_capture_uploader.
module tb_adc_capture_uploader;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [7:0]         cmd_type = 8'h00;
    logic [15:0]        cmd_length = 16'h0;
    logic [7:0]         cmd_data = 8'h00;
    logic [15:0]        cmd_data_index = 16'h0;
    logic               cmd_start = 1'b0;
    logic               cmd_data_valid = 1'b0;
    logic               cmd_done = 1'b0;
    logic               cmd_ready;
    logic               abort = 1'b0;
    logic signed [13:0] adc_data = 14'sd0;
    logic               adc_valid = 1'b0;
    logic [7:0]         upload_data;
    logic               upload_valid;
    logic               upload_ready = 1'b1;
    logic               busy;
    logic               capture_done;

    int n_checks = 0;
    int n_err = 0;
    int n_done = 0;
    int n_stall = 0;
    int cyc = 0;
    int first_cyc = -1;
    int last_cyc = -1;
    logic       stall_pend = 1'b0;
    logic [7:0] stall_data = 8'h00;
    logic [7:0] got[$];
    logic [7:0] exp_q[$];

    adc_capture_uploader dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_type       (cmd_type),
        .cmd_length     (cmd_length),
        .cmd_data       (cmd_data),
        .cmd_data_index (cmd_data_index),
        .cmd_start      (cmd_start),
        .cmd_data_valid (cmd_data_valid),
        .cmd_done       (cmd_done),
        .cmd_ready      (cmd_ready),
        .abort          (abort),
        .adc_data       (adc_data),
        .adc_valid      (adc_valid),
        .upload_data    (upload_data),
        .upload_valid   (upload_valid),
        .upload_ready   (upload_ready),
        .busy           (busy),
        .capture_done   (capture_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Receiver side: record accepted bytes and verify held data during stalls.
    always @(negedge clk) begin
        if (rst_n) begin
            if (stall_pend) begin
                n_stall++;
                check("stall_valid", {31'd0, upload_valid}, 32'd1);
                check("stall_data", {24'd0, upload_data}, {24'd0, stall_data});
            end
            stall_pend = upload_valid && !upload_ready;
            stall_data = upload_data;
            if (upload_valid && upload_ready) begin
                got.push_back(upload_data);
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (capture_done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_run();
        got.delete();
        exp_q.delete();
        n_done = 0;
        n_stall = 0;
        first_cyc = -1;
        last_cyc = -1;
    endtask

    task automatic send_cmd(input logic [7:0] flags, input logic [15:0] len, input logic [31:0] rate);
        logic [7:0] hdr [7];
        hdr = '{flags, len[15:8], len[7:0], rate[31:24], rate[23:16], rate[15:8], rate[7:0]};
        cmd_type = 8'hFD;
        cmd_length = 16'd7;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            cmd_data_valid = 1'b1;
            cmd_data_index = 16'(i);
            cmd_data = hdr[i];
            tick();
        end
        cmd_data_valid = 1'b0;
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
        tick();
    endtask

    task automatic feed(input int s);
        adc_valid = 1'b1;
        adc_data = 14'(s);
        tick();
    endtask

    task automatic feed_stop();
        adc_valid = 1'b0;
    endtask

    task automatic exp_hdr(input int len);
        exp_q.push_back(8'hFD);
        exp_q.push_back(8'((len >> 8) & 255));
        exp_q.push_back(8'(len & 255));
    endtask

    task automatic exp_sample(input int s);
        int raw;
        raw = (s + 8192) & 16383;
        exp_q.push_back(8'(raw & 255));
        exp_q.push_back(8'(raw >> 8));
    endtask

    // Run until the whole packet is in and the block is idle; pattern 1,0,0,1 when bp set.
    task automatic wait_upload(input int budget, input bit bp);
        int c = 0;
        logic [3:0] pat = 4'b1001;
        while ((got.size() < exp_q.size() || busy) && c < budget) begin
            upload_ready = bp ? pat[c % 4] : 1'b1;
            tick();
            c++;
        end
        upload_ready = 1'b1;
        check("wait_in_budget", {31'd0, c < budget}, 32'd1);
    endtask

    task automatic check_seq(input string tag);
        int bad = 0;
        check({tag, "_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            if (got[i] !== exp_q[i]) bad++;
        check({tag, "_bytes_wrong"}, 32'(bad), 32'd0);
    endtask

    initial begin
        repeat (3) tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_upload_valid", {31'd0, upload_valid}, 32'd0);
        check("rst_upload_data", {24'd0, upload_data}, 32'd0);
        check("rst_capture_done", {31'd0, capture_done}, 32'd0);
        rst_n = 1'b1;
        tick();

        // Immediate capture, every sample, ready held high.
        clear_run();
        send_cmd(8'h00, 16'd4, 32'd0);
        feed(-8192); feed(-1); feed(0); feed(8191);
        feed_stop();
        exp_hdr(4);
        exp_sample(-8192); exp_sample(-1); exp_sample(0); exp_sample(8191);
        wait_upload(200, 1'b0);
        check_seq("imm");
        check("imm_done_pulses", 32'(n_done), 32'd1);
        check("imm_no_bubbles", 32'(last_cyc - first_cyc), 32'd10);
        check("imm_idle_ready", {31'd0, cmd_ready}, 32'd1);

        // Decimation by two: ramp 0..9 keeps odd samples.
        clear_run();
        send_cmd(8'h00, 16'd3, 32'h8000_0000);
        for (int i = 0; i < 10; i++) feed(i);
        feed_stop();
        exp_hdr(3);
        exp_sample(1); exp_sample(3); exp_sample(5);
        wait_upload(200, 1'b0);
        check_seq("decim");
        check("decim_done_pulses", 32'(n_done), 32'd1);

        // Zero-crossing trigger.
        clear_run();
        send_cmd(8'h01, 16'd2, 32'd0);
        feed(-5); feed(-3); feed(-1);
        feed_stop();
        tick();
        check("arm_no_bytes", 32'(got.size()), 32'd0);
        check("arm_upload_valid", {31'd0, upload_valid}, 32'd0);
        check("arm_busy", {31'd0, busy}, 32'd1);
        check("arm_cmd_ready", {31'd0, cmd_ready}, 32'd0);
        feed(2); feed(4); feed(6);
        feed_stop();
        exp_hdr(2);
        exp_sample(2); exp_sample(4);
        wait_upload(200, 1'b0);
        check_seq("trig");

        // Backpressure: same packet as the first run.
        clear_run();
        send_cmd(8'h00, 16'd4, 32'd0);
        feed(-8192); feed(-1); feed(0); feed(8191);
        feed_stop();
        exp_hdr(4);
        exp_sample(-8192); exp_sample(-1); exp_sample(0); exp_sample(8191);
        wait_upload(400, 1'b1);
        check_seq("bp");
        check("bp_stalls_seen", {31'd0, n_stall > 0}, 32'd1);

        // Zero length: header only, no capture.
        clear_run();
        send_cmd(8'h00, 16'd0, 32'd0);
        exp_hdr(0);
        wait_upload(100, 1'b0);
        check_seq("len0");
        check("len0_done_pulses", 32'(n_done), 32'd0);

        // Oversized length clamps to the RAM depth.
        clear_run();
        send_cmd(8'h00, 16'd5000, 32'd0);
        exp_hdr(4096);
        for (int i = 0; i < 4096; i++) begin
            feed(((i * 7) % 16384) - 8192);
            exp_sample(((i * 7) % 16384) - 8192);
        end
        feed_stop();
        wait_upload(20000, 1'b0);
        check_seq("clamp");
        check("clamp_hdr_hi", {24'd0, got.size() > 1 ? got[1] : 8'hxx}, 32'h10);
        check("clamp_done_pulses", 32'(n_done), 32'd1);

        // Abort in the middle of the data bytes.
        clear_run();
        send_cmd(8'h00, 16'd4, 32'd0);
        feed(10); feed(20); feed(30); feed(40);
        feed_stop();
        for (int c = 0; c < 100 && got.size() < 5; c++) tick();
        check("abort_tx_reached", {31'd0, got.size() >= 5}, 32'd1);
        abort = 1'b1;
        tick();
        check("abort_tx_valid", {31'd0, upload_valid}, 32'd0);
        check("abort_tx_busy", {31'd0, busy}, 32'd0);
        check("abort_tx_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        abort = 1'b0;
        tick();

        // Abort while armed.
        clear_run();
        send_cmd(8'h01, 16'd2, 32'd0);
        feed(-5); feed(-3);
        feed_stop();
        abort = 1'b1;
        tick();
        check("abort_arm_valid", {31'd0, upload_valid}, 32'd0);
        check("abort_arm_busy", {31'd0, busy}, 32'd0);
        check("abort_arm_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        abort = 1'b0;
        tick();

        // A normal command after the aborts.
        clear_run();
        send_cmd(8'h00, 16'd2, 32'd0);
        feed(100); feed(-100);
        feed_stop();
        exp_hdr(2);
        exp_sample(100); exp_sample(-100);
        wait_upload(200, 1'b0);
        check_seq("after_abort");
        check("after_abort_done_pulses", 32'(n_done), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
